// File: rtl/ddr_hit_judge.sv
`default_nettype none
// ============================================================================
//  Module      : ddr_hit_judge
//  Description : Two-player rhythm-game judge. Accepts one note (arrow mask)
//                at a time, watches both players' button rises over a
//                bounded window, and emits one hit or miss pulse per player
//                along with saturating score and combo counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module ddr_hit_judge #(
   parameter int WINDOW     = 25000000,
   parameter int HIT_POINTS = 10
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        note_valid,
   input  logic [3:0]  note_dir,
   output logic        note_ready,
   input  logic [3:0]  a_btn,
   input  logic [3:0]  b_btn,
   output logic        a_hit,
   output logic        b_hit,
   output logic        a_miss,
   output logic        b_miss,
   output logic [15:0] a_score,
   output logic [15:0] b_score,
   output logic [7:0]  a_combo,
   output logic [7:0]  b_combo
);

   localparam logic [24:0] C_WIN_LOAD = 25'(WINDOW - 1);
   localparam logic [16:0] C_HIT_PTS  = 17'(HIT_POINTS);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_JUDGE  = 2'd1,
      S_RESULT = 2'd2
   } state_t;

   state_t      state_q,   state_d;
   logic [24:0] cnt_q,     cnt_d;
   logic [3:0]  dir_q,     dir_d;
   logic [3:0]  prev_a_q,  prev_a_d;
   logic [3:0]  prev_b_q,  prev_b_d;
   logic        a_res_q,   a_res_d;
   logic        b_res_q,   b_res_d;
   logic        a_good_q,  a_good_d;
   logic        b_good_q,  b_good_d;
   logic        a_hit_q,   a_hit_d;
   logic        b_hit_q,   b_hit_d;
   logic        a_miss_q,  a_miss_d;
   logic        b_miss_q,  b_miss_d;
   logic [15:0] a_score_q, a_score_d;
   logic [15:0] b_score_q, b_score_d;
   logic [7:0]  a_combo_q, a_combo_d;
   logic [7:0]  b_combo_q, b_combo_d;

   logic [3:0]  a_rise;
   logic [3:0]  b_rise;
   logic        a_final_hit;
   logic        b_final_hit;

   // Score add that clamps at the 16-bit ceiling instead of wrapping.
   function automatic logic [15:0] score_add(input logic [15:0] s);
      logic [16:0] sum;
      sum = {1'b0, s} + C_HIT_PTS;
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

   // Combo increment that sticks at 255.
   function automatic logic [7:0] combo_inc(input logic [7:0] c);
      return (c == 8'hFF) ? 8'hFF : c + 8'd1;
   endfunction

   // Edge detect against the previous-cycle level; prev is forced high in reset
   // so a button held through reset never looks like a fresh press.
   always_comb begin
      a_rise = a_btn & ~prev_a_q;
      b_rise = b_btn & ~prev_b_q;
   end

   // Next-state computation for the note FSM, judgement flags and counters.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      dir_d       = dir_q;
      prev_a_d    = a_btn;
      prev_b_d    = b_btn;
      a_res_d     = a_res_q;
      b_res_d     = b_res_q;
      a_good_d    = a_good_q;
      b_good_d    = b_good_q;
      a_hit_d     = 1'b0;
      b_hit_d     = 1'b0;
      a_miss_d    = 1'b0;
      b_miss_d    = 1'b0;
      a_score_d   = a_score_q;
      b_score_d   = b_score_q;
      a_combo_d   = a_combo_q;
      b_combo_d   = b_combo_q;
      a_final_hit = 1'b0;
      b_final_hit = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (note_valid) begin
               dir_d    = note_dir;
               cnt_d    = C_WIN_LOAD;
               a_res_d  = 1'b0;
               b_res_d  = 1'b0;
               a_good_d = 1'b0;
               b_good_d = 1'b0;
               state_d  = S_JUDGE;
            end
         end

         S_JUDGE: begin
            if (cnt_q != 25'd0) begin
               cnt_d = cnt_q - 25'd1;
            end

            // A wrong arrow in the same cycle as a right one counts as a miss.
            if (!a_res_q) begin
               if ((a_rise & ~dir_q) != 4'd0) begin
                  a_res_d  = 1'b1;
                  a_good_d = 1'b0;
               end else if ((a_rise & dir_q) != 4'd0) begin
                  a_res_d  = 1'b1;
                  a_good_d = 1'b1;
               end
            end
            if (!b_res_q) begin
               if ((b_rise & ~dir_q) != 4'd0) begin
                  b_res_d  = 1'b1;
                  b_good_d = 1'b0;
               end else if ((b_rise & dir_q) != 4'd0) begin
                  b_res_d  = 1'b1;
                  b_good_d = 1'b1;
               end
            end

            // Close the note once both players are decided or the window ends;
            // anyone still undecided at that point is scored as a miss.
            if ((a_res_d && b_res_d) || (cnt_q == 25'd0)) begin
               state_d     = S_RESULT;
               a_final_hit = a_res_d & a_good_d;
               b_final_hit = b_res_d & b_good_d;
               a_hit_d     = a_final_hit;
               a_miss_d    = ~a_final_hit;
               b_hit_d     = b_final_hit;
               b_miss_d    = ~b_final_hit;
               if (a_final_hit) begin
                  a_score_d = score_add(a_score_q);
                  a_combo_d = combo_inc(a_combo_q);
               end else begin
                  a_combo_d = 8'd0;
               end
               if (b_final_hit) begin
                  b_score_d = score_add(b_score_q);
                  b_combo_d = combo_inc(b_combo_q);
               end else begin
                  b_combo_d = 8'd0;
               end
            end
         end

         S_RESULT: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers; reset drops straight back to IDLE.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= 25'd0;
         dir_q     <= 4'd0;
         prev_a_q  <= 4'hF;
         prev_b_q  <= 4'hF;
         a_res_q   <= 1'b0;
         b_res_q   <= 1'b0;
         a_good_q  <= 1'b0;
         b_good_q  <= 1'b0;
         a_hit_q   <= 1'b0;
         b_hit_q   <= 1'b0;
         a_miss_q  <= 1'b0;
         b_miss_q  <= 1'b0;
         a_score_q <= 16'd0;
         b_score_q <= 16'd0;
         a_combo_q <= 8'd0;
         b_combo_q <= 8'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         dir_q     <= dir_d;
         prev_a_q  <= prev_a_d;
         prev_b_q  <= prev_b_d;
         a_res_q   <= a_res_d;
         b_res_q   <= b_res_d;
         a_good_q  <= a_good_d;
         b_good_q  <= b_good_d;
         a_hit_q   <= a_hit_d;
         b_hit_q   <= b_hit_d;
         a_miss_q  <= a_miss_d;
         b_miss_q  <= b_miss_d;
         a_score_q <= a_score_d;
         b_score_q <= b_score_d;
         a_combo_q <= a_combo_d;
         b_combo_q <= b_combo_d;
      end
   end

   assign note_ready = (state_q == S_IDLE);
   assign a_hit      = a_hit_q;
   assign b_hit      = b_hit_q;
   assign a_miss     = a_miss_q;
   assign b_miss     = b_miss_q;
   assign a_score    = a_score_q;
   assign b_score    = b_score_q;
   assign a_combo    = a_combo_q;
   assign b_combo    = b_combo_q;

endmodule
`default_nettype wire

// File: tb/tb_ddr_hit_judge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ddr_hit_judge
//  Description : Self-checking bench for ddr_hit_judge (WINDOW=8,
//                HIT_POINTS=10): directed notes, randomized notes against a
//                per-note outcome model, reset abort and score saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr_hit_judge;

   localparam int W  = 8;
   localparam int HP = 10;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        note_valid = 1'b0;
   logic [3:0]  note_dir = 4'd0;
   logic        note_ready;
   logic [3:0]  a_btn = 4'd0;
   logic [3:0]  b_btn = 4'd0;
   logic        a_hit, b_hit, a_miss, b_miss;
   logic [15:0] a_score, b_score;
   logic [7:0]  a_combo, b_combo;
   logic [3:0]  pulses;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference state: scores/combos per player (0 = A, 1 = B)
   int m_score [2];
   int m_combo [2];

   // Button levels per note: index 0 = accept cycle, 1..W = JUDGE cycles
   logic [3:0] la [0:W];
   logic [3:0] lb [0:W];

   always #5 clock = ~clock;

   assign pulses = {a_hit, a_miss, b_hit, b_miss};

   ddr_hit_judge #(.WINDOW(W), .HIT_POINTS(HP)) dut (
      .clock      (clock),
      .reset      (reset),
      .note_valid (note_valid),
      .note_dir   (note_dir),
      .note_ready (note_ready),
      .a_btn      (a_btn),
      .b_btn      (b_btn),
      .a_hit      (a_hit),
      .b_hit      (b_hit),
      .a_miss     (a_miss),
      .b_miss     (b_miss),
      .a_score    (a_score),
      .b_score    (b_score),
      .a_combo    (a_combo),
      .b_combo    (b_combo)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_totals(input string tag);
      chk({tag, "_a_score"}, {16'd0, a_score}, 32'(m_score[0]));
      chk({tag, "_b_score"}, {16'd0, b_score}, 32'(m_score[1]));
      chk({tag, "_a_combo"}, {24'd0, a_combo}, 32'(m_combo[0]));
      chk({tag, "_b_combo"}, {24'd0, b_combo}, 32'(m_combo[1]));
   endtask

   // First JUDGE cycle with any new press decides the player; a press
   // touching any arrow outside dir is a miss, otherwise a hit.
   task automatic judge_player(input logic [3:0] dir, input bit pb, output int k, output bit hit);
      logic [3:0] cur;
      logic [3:0] prv;
      logic [3:0] r;
      k   = 0;
      hit = 1'b0;
      for (int c = 1; c <= W; c++) begin
         cur = pb ? lb[c] : la[c];
         prv = pb ? lb[c-1] : la[c-1];
         r   = cur & ~prv;
         if (k == 0 && r != 4'd0) begin
            k   = c;
            hit = ((r & ~dir) == 4'd0);
         end
      end
   endtask

   task automatic apply_outcome(input int p, input bit hit);
      if (hit) begin
         m_score[p] = (m_score[p] + HP > 65535) ? 65535 : m_score[p] + HP;
         m_combo[p] = (m_combo[p] + 1 > 255) ? 255 : m_combo[p] + 1;
      end else begin
         m_combo[p] = 0;
      end
   endtask

   task automatic run_note(input logic [3:0] dir, input bit noise);
      int ka, kb, e;
      bit ha, hb, fa, fb;
      logic [3:0] exp_p;
      judge_player(dir, 1'b0, ka, ha);
      judge_player(dir, 1'b1, kb, hb);
      e  = (ka != 0 && kb != 0) ? ((ka > kb) ? ka : kb) : W;
      fa = (ka != 0) && ha;
      fb = (kb != 0) && hb;
      exp_p = {fa, !fa, fb, !fb};
      apply_outcome(0, fa);
      apply_outcome(1, fb);

      @(negedge clock);
      chk("ready_before_accept", {31'd0, note_ready}, 32'd1);
      note_valid = 1'b1;
      note_dir   = dir;
      a_btn      = la[0];
      b_btn      = lb[0];
      for (int c = 1; c <= e + 2; c++) begin
         @(negedge clock);
         if (c <= e) begin
            chk("ready_judge", {31'd0, note_ready}, 32'd0);
            chk("pulse_judge", {28'd0, pulses}, 32'd0);
         end else if (c == e + 1) begin
            chk("ready_result", {31'd0, note_ready}, 32'd0);
            chk("pulse_result", {28'd0, pulses}, {28'd0, exp_p});
            chk_totals("result");
         end else begin
            chk("ready_return", {31'd0, note_ready}, 32'd1);
            chk("pulse_after", {28'd0, pulses}, 32'd0);
         end
         if (c <= W) begin
            a_btn = la[c];
            b_btn = lb[c];
         end
         if (noise && c <= e + 1) begin
            note_valid = 1'($urandom_range(0, 1));
            note_dir   = 4'($urandom);
         end else begin
            note_valid = 1'b0;
         end
      end
   endtask

   task automatic gen_levels(input logic [3:0] dir);
      bit a_idle, b_idle;
      a_idle = ($urandom_range(0, 3) == 0);
      b_idle = ($urandom_range(0, 3) == 0);
      la[0]  = 4'($urandom);
      lb[0]  = 4'($urandom);
      for (int c = 1; c <= W; c++) begin
         la[c] = la[c-1];
         lb[c] = lb[c-1];
         if (!a_idle && $urandom_range(0, 3) == 0)
            la[c] = $urandom_range(0, 1) ? (4'($urandom) & dir) : 4'($urandom);
         if (!b_idle && $urandom_range(0, 3) == 0)
            lb[c] = $urandom_range(0, 1) ? (4'($urandom) & dir) : 4'($urandom);
      end
   endtask

   task automatic set_levels(input logic [3:0] va0, input logic [3:0] va, input int ka_from,
                             input logic [3:0] vb0, input logic [3:0] vb, input int kb_from);
      for (int c = 0; c <= W; c++) begin
         la[c] = (c >= ka_from) ? va : va0;
         lb[c] = (c >= kb_from) ? vb : vb0;
      end
   endtask

   initial begin
      logic [3:0] d;
      m_score[0] = 0; m_score[1] = 0;
      m_combo[0] = 0; m_combo[1] = 0;

      // Reset with A holding an arrow; reset takes effect without a clock edge
      a_btn = 4'b0010;
      #2 reset = 1'b1;
      #1;
      chk("rst_ready", {31'd0, note_ready}, 32'd1);
      chk("rst_pulses", {28'd0, pulses}, 32'd0);
      chk_totals("rst");
      repeat (3) @(negedge clock);
      chk("rst_ready_held", {31'd0, note_ready}, 32'd1);
      reset = 1'b0;

      // Held level across reset release must not count as a press
      set_levels(4'b0010, 4'b0010, 0, 4'b0000, 4'b0000, 0);
      run_note(4'b0010, 1'b0);

      // Both players press the right arrow in JUDGE cycle 2
      set_levels(4'b0000, 4'b0001, 2, 4'b0000, 4'b0001, 2);
      run_note(4'b0001, 1'b0);
      chk("dir38_a_score", {16'd0, a_score}, 32'd10);
      chk("dir38_b_combo", {24'd0, b_combo}, 32'd1);

      // A presses a right and a wrong arrow together; B idle -> both time out
      set_levels(4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0);
      la[3] = 4'b0101;
      run_note(4'b0100, 1'b0);

      // A hits at cycle 1, later wrong press ignored; B times out
      set_levels(4'b0000, 4'b1000, 1, 4'b0000, 4'b0000, 0);
      for (int c = 3; c <= W; c++) la[c] = 4'b1100;
      run_note(4'b1000, 1'b0);

      // Multi-hot target, subset press is a hit; empty target, any press misses
      set_levels(4'b0000, 4'b0010, 1, 4'b0000, 4'b1010, 2);
      run_note(4'b1010, 1'b0);
      set_levels(4'b0000, 4'b0001, 1, 4'b0000, 4'b0000, 0);
      run_note(4'b0000, 1'b0);

      // Randomized notes, with note_valid noise while busy
      for (int n = 0; n < 60; n++) begin
         d = 4'($urandom);
         gen_levels(d);
         run_note(d, 1'($urandom_range(0, 1)));
      end

      // Reset in JUDGE cycle 4 abandons the note
      @(negedge clock);
      note_valid = 1'b1;
      note_dir   = 4'b0001;
      a_btn      = 4'b0000;
      b_btn      = 4'b0000;
      @(negedge clock);
      note_valid = 1'b0;
      repeat (3) @(negedge clock);
      chk("abort_in_judge", {31'd0, note_ready}, 32'd0);
      a_btn = 4'b0001;
      b_btn = 4'b0001;
      #1 reset = 1'b1;
      #1;
      m_score[0] = 0; m_score[1] = 0;
      m_combo[0] = 0; m_combo[1] = 0;
      chk("abort_ready", {31'd0, note_ready}, 32'd1);
      chk("abort_pulses", {28'd0, pulses}, 32'd0);
      chk_totals("abort");
      @(negedge clock);
      @(negedge clock);
      chk("abort_pulses_late", {28'd0, pulses}, 32'd0);
      reset = 1'b0;

      // Saturation: 6553 hits reach 65530 and a pinned combo, one more clamps
      set_levels(4'b0000, 4'b0001, 1, 4'b0000, 4'b0001, 1);
      for (int n = 0; n < 6553; n++) run_note(4'b0001, 1'b0);
      chk("sat_pre_score", {16'd0, a_score}, 32'd65530);
      chk("sat_pre_combo", {24'd0, a_combo}, 32'd255);
      run_note(4'b0001, 1'b0);
      chk("sat_score", {16'd0, a_score}, 32'd65535);
      chk("sat_combo", {24'd0, a_combo}, 32'd255);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ddr_hit_judge.md
DDR_HIT_JUDGE -- requirements
Module: ddr_hit_judge

Interface
REQ-001 SHALL have parameter WINDOW, default 25000000, giving the judge window length in clock cycles; legal range 1..2^25-1.
REQ-002 SHALL have parameter HIT_POINTS, default 10, giving the points added per hit.
REQ-003 clock  input  1  system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 note_valid  input  1  note offer from the pattern source.
REQ-006 note_dir  input  4  target arrow mask: bit0 up, bit1 down, bit2 left, bit3 right.
REQ-007 note_ready  output  1  high only in IDLE; a note is accepted on a cycle where note_valid and note_ready are both high.
REQ-008 a_btn, b_btn  input  4 each  debounced button levels for player A and player B, using the same bit order as note_dir.
REQ-009 a_hit, b_hit, a_miss, b_miss  output  1 each  one-cycle judgement pulses.
REQ-010 a_score, b_score  output  16 each  accumulated scores.
REQ-011 a_combo, b_combo  output  8 each  consecutive-hit counts.

Function
REQ-012 SHALL keep per-player registers prev_a and prev_b, updated every cycle in every state.
REQ-013 SHALL compute rise = btn & ~prev for each player.
REQ-014 SHALL ignore rises that occur outside the JUDGE state.
REQ-015 SHALL implement the state machine IDLE -> JUDGE -> RESULT -> IDLE.
REQ-016 IDLE: when note_valid and note_ready are both high, SHALL latch note_dir, load the window counter with WINDOW-1, clear both per-player resolved flags, and move to JUDGE.
REQ-017 IDLE: note_valid without an accept SHALL have no effect; note_valid is ignored in every state except IDLE.
REQ-018 JUDGE, per unresolved player, when rise & ~dir is nonzero: SHALL mark the player resolved with a miss; a wrong press wins over a simultaneous correct press.
REQ-019 JUDGE, per unresolved player, when rise & dir is nonzero and rise & ~dir is zero: SHALL mark the player resolved with a hit.
REQ-020 A resolved player's later rises within the same note SHALL be ignored.
REQ-021 With dir = 0, any rise SHALL be a miss.
REQ-022 With a multi-hot dir, a rise on any subset of the dir bits SHALL be a hit.
REQ-023 JUDGE SHALL decrement the counter each cycle.
REQ-024 JUDGE SHALL move to RESULT at the edge where both players are resolved (counting resolutions made that cycle) or the counter equals 0, whichever comes first.
REQ-025 At the JUDGE -> RESULT edge, any player still unresolved SHALL be judged a miss.
REQ-026 At the JUDGE -> RESULT edge, SHALL register the hit and miss pulses and update score and combo.
REQ-027 The hit and miss pulses SHALL be high for exactly the one RESULT cycle; exactly one of hit or miss SHALL pulse per player per note.
REQ-028 On a hit: score += HIT_POINTS, saturating at 65535; combo += 1, saturating at 255.
REQ-029 On a miss: score unchanged; combo set to 0.
REQ-030 RESULT SHALL move to IDLE unconditionally on the next edge.
REQ-031 Latency: a note accepted at edge T has JUDGE cycles T+1 .. T+WINDOW at most, RESULT in the following cycle, and note_ready high again one cycle after RESULT; the minimum note period is 3 cycles and the timeout note period is WINDOW+2 cycles.
REQ-032 Players SHALL be judged independently within the same note.

Reset
REQ-033 On reset assertion, SHALL go immediately, without waiting for a clock edge, to IDLE.
REQ-034 Reset SHALL clear all pulse outputs to 0, scores to 0, combos to 0 and the counter to 0, and SHALL set prev_a and prev_b to 4'hF.
REQ-035 Setting prev to 4'hF SHALL ensure that buttons held through reset produce no rise.
REQ-036 note_ready SHALL read 1 during and after reset.
REQ-037 Reset asserted mid-JUDGE SHALL abandon the note with no pulses and no score change.

Verification (WINDOW=8, HIT_POINTS=10)
REQ-038 Accept note_dir=0001; A presses 0001 and B presses 0001 at JUDGE cycle 2 -> RESULT on the next cycle; a_hit and b_hit pulse once; scores 10/10; combos 1/1.
REQ-039 note_dir=0100; A presses 0101 in one cycle; B idle -> at timeout, a_miss and b_miss pulse; scores unchanged; combos 0; note_ready returns 10 cycles after accept.
REQ-040 Hold a_btn=0010 across reset release, then accept note_dir=0010 with no new press -> timeout miss for A, with no hit from the held level.
REQ-041 Preload A combo 255 and score 65530 via repeated hits; one further hit -> score 65535 and combo 255, both saturated.
REQ-042 Pulse note_valid during JUDGE and RESULT -> no accept; assert reset at JUDGE cycle 4 -> no pulses, outputs zero, note_ready=1.
REQ-043 A hits at cycle 1, then A presses a wrong arrow at cycle 3, and B never presses -> a_hit only (the later press ignored), b_miss at timeout.
